// File: rtl/prefetch_fetch_unit_if.sv
// rtl/prefetch_fetch_unit_if.sv - memory-fetch and decode-handshake bundle for the prefetch unit
interface prefetch_fetch_unit_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  if_valid;
    logic                  if_ready;
    logic [DATA_WIDTH-1:0] if_ir;
    logic [ADDR_WIDTH-1:0] if_pc;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        output if_valid,
        input  if_ready,
        output if_ir,
        output if_pc
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        input  if_valid,
        output if_ready,
        input  if_ir,
        input  if_pc
    );
endinterface

// File: rtl/prefetch_fetch_unit.sv
// rtl/prefetch_fetch_unit.sv - instruction prefetch front end: memory fetch FSM feeding a {pc, ir} FIFO
module prefetch_fetch_unit #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    prefetch_fetch_unit_if.master          bus,
    input  logic                           redirect,
    input  logic [ADDR_WIDTH-1:0]          redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0]     fifo_level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        KILL = 2'd2
    } stateType;

    stateType              state;
    stateType              stateNext;
    logic [ADDR_WIDTH-1:0] fetchPc;
    logic [ADDR_WIDTH-1:0] fetchPcNext;
    logic [ADDR_WIDTH-1:0] pendingPc;
    logic [ADDR_WIDTH-1:0] pendingPcNext;

    logic [ADDR_WIDTH-1:0] pcMem [DEPTH];
    logic [DATA_WIDTH-1:0] irMem [DEPTH];
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      rdPtr;
    logic [LVL_W-1:0]      level;
    logic [LVL_W-1:0]      levelAfter;

    logic empty;
    logic headValid;
    logic pop;
    logic push;
    logic space;

    assign empty      = (level == '0);
    assign headValid  = !empty && !redirect;
    assign pop        = headValid && bus.if_ready;
    assign push       = (state == REQ) && bus.mem_ack && !redirect;
    assign levelAfter = level + LVL_W'(push) - LVL_W'(pop);
    // Room is judged on next cycle's occupancy so a request in flight can always land.
    assign space      = (levelAfter < LVL_W'(DEPTH));

    always_comb begin
        stateNext     = state;
        fetchPcNext   = fetchPc;
        pendingPcNext = pendingPc;
        case (state)
            IDLE: begin
                if (redirect) begin
                    fetchPcNext = redirect_pc;
                    stateNext   = REQ;
                end else if (space) begin
                    stateNext = REQ;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    if (redirect) begin
                        fetchPcNext = redirect_pc;
                    end else begin
                        fetchPcNext = fetchPc + ADDR_WIDTH'(1);
                        stateNext   = space ? REQ : IDLE;
                    end
                end else if (redirect) begin
                    pendingPcNext = redirect_pc;
                    stateNext     = KILL;
                end
            end
            KILL: begin
                // Old request must still finish on its original address; its data is dropped.
                if (bus.mem_ack) begin
                    fetchPcNext = redirect ? redirect_pc : pendingPc;
                    stateNext   = REQ;
                end else if (redirect) begin
                    pendingPcNext = redirect_pc;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fetchPc   <= RESET_PC;
            pendingPc <= RESET_PC;
            wrPtr     <= '0;
            rdPtr     <= '0;
            level     <= '0;
        end else begin
            state     <= stateNext;
            fetchPc   <= fetchPcNext;
            pendingPc <= pendingPcNext;
            if (redirect) begin
                wrPtr <= '0;
                rdPtr <= '0;
                level <= '0;
            end else begin
                if (push) begin
                    wrPtr <= wrPtr + PTR_W'(1);
                end
                if (pop) begin
                    rdPtr <= rdPtr + PTR_W'(1);
                end
                level <= levelAfter;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pcMem[wrPtr] <= fetchPc;
            irMem[wrPtr] <= bus.mem_rdata;
        end
    end

    assign bus.mem_req  = (state != IDLE);
    assign bus.mem_addr = fetchPc;
    assign bus.if_valid = headValid;
    assign bus.if_ir    = empty ? '0 : irMem[rdPtr];
    assign bus.if_pc    = empty ? '0 : pcMem[rdPtr];
    assign fifo_level   = level;
endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// tb/tb_prefetch_fetch_unit.sv - directed self-checking bench for prefetch_fetch_unit
module tb_prefetch_fetch_unit;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    prefetch_fetch_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    prefetch_fetch_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

    logic          redirect   = 1'b0;
    logic [AW-1:0] redirectPc = '0;
    logic [2:0]    fifoLevel;
    logic [2:0]    fifoLevel2;

    prefetch_fetch_unit #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.master),
        .redirect(redirect), .redirect_pc(redirectPc), .fifo_level(fifoLevel)
    );

    prefetch_fetch_unit #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(16'hFFFE)
    ) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.master),
        .redirect(1'b0), .redirect_pc(16'h0000), .fifo_level(fifoLevel2)
    );

    // Zero-wait memory and always-ready decode for the wrap-around instance.
    assign bus2.mem_ack   = bus2.mem_req;
    assign bus2.mem_rdata = bus2.mem_addr ^ 16'hA5A5;
    assign bus2.if_ready  = 1'b1;

    int checkCount = 0;
    int errorCount = 0;
    int waitCnt    = 0;
    int ackDelay   = 1;
    bit autoMem    = 1'b1;

    logic [AW-1:0] gotPc  [$];
    logic [DW-1:0] gotIr  [$];
    logic [AW-1:0] gotPc2 [$];
    logic [DW-1:0] gotIr2 [$];

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        if (bus.if_valid && bus.if_ready) begin
            gotPc.push_back(bus.if_pc);
            gotIr.push_back(bus.if_ir);
        end
        if (bus2.if_valid && bus2.if_ready && gotPc2.size() < 4) begin
            gotPc2.push_back(bus2.if_pc);
            gotIr2.push_back(bus2.if_ir);
        end
        @(posedge clk);
        #1;
        if (autoMem) begin
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                waitCnt     = 0;
            end
            if (!bus.mem_req) begin
                waitCnt = 0;
            end else if (waitCnt == ackDelay) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = bus.mem_addr ^ 16'hA5A5;
            end else begin
                waitCnt++;
            end
        end
    endtask

    task automatic applyReset();
        rst         = 1'b0;
        bus.mem_ack = 1'b0;
        waitCnt     = 0;
        redirect    = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        gotPc.delete();
        gotIr.delete();
    endtask

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        bus.if_ready  = 1'b1;

        // Reset values
        tick();
        tick();
        checkValue("rst_mem_req",  32'(bus.mem_req),  32'd0);
        checkValue("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        checkValue("rst_if_valid", 32'(bus.if_valid), 32'd0);
        checkValue("rst_if_ir",    32'(bus.if_ir),    32'h0);
        checkValue("rst_if_pc",    32'(bus.if_pc),    32'h0);
        checkValue("rst_level",    32'(fifoLevel),    32'd0);

        // 1: one wait-state memory, decode always ready -> one word every 2 cycles
        ackDelay = 1;
        rst      = 1'b1;
        repeat (20) tick();
        checkValue("t1_count", 32'(gotPc.size()), 32'd9);
        for (int k = 0; k < 9 && k < gotPc.size(); k++) begin
            checkValue("t1_pc", 32'(gotPc[k]), 32'(k));
            checkValue("t1_ir", 32'(gotIr[k]), 32'(16'(k) ^ 16'hA5A5));
        end

        // 5: RESET_PC = FFFE wraps through zero
        checkValue("t5_count", 32'(gotPc2.size()), 32'd4);
        if (gotPc2.size() == 4) begin
            checkValue("t5_pc0", 32'(gotPc2[0]), 32'hFFFE);
            checkValue("t5_pc1", 32'(gotPc2[1]), 32'hFFFF);
            checkValue("t5_pc2", 32'(gotPc2[2]), 32'h0000);
            checkValue("t5_pc3", 32'(gotPc2[3]), 32'h0001);
            checkValue("t5_ir2", 32'(gotIr2[2]), 32'hA5A5);
        end

        // 2: decode stalled, memory acks every cycle -> FIFO fills to DEPTH and fetch stops
        ackDelay     = 0;
        bus.if_ready = 1'b0;
        applyReset();
        repeat (10) tick();
        checkValue("t2_level",    32'(fifoLevel),    32'd4);
        checkValue("t2_mem_req",  32'(bus.mem_req),  32'd0);
        checkValue("t2_no_pop",   32'(gotPc.size()), 32'd0);
        checkValue("t2_if_valid", 32'(bus.if_valid), 32'd1);
        checkValue("t2_head_pc",  32'(bus.if_pc),    32'h0);
        checkValue("t2_head_ir",  32'(bus.if_ir),    32'hA5A5);
        bus.if_ready = 1'b1;
        tick();
        checkValue("t2_resume_req",  32'(bus.mem_req),  32'd1);
        checkValue("t2_resume_addr", 32'(bus.mem_addr), 32'h4);
        checkValue("t2_resume_lvl",  32'(fifoLevel),    32'd3);
        repeat (12) tick();
        checkValue("t2_count", 32'(gotPc.size() >= 6), 32'd1);
        for (int k = 0; k < 6 && k < gotPc.size(); k++) begin
            checkValue("t2_order", 32'(gotPc[k]), 32'(k));
        end

        // 3: redirect during a slow request with two words buffered
        ackDelay     = 3;
        bus.if_ready = 1'b0;
        applyReset();
        for (int i = 0; i < 40 && fifoLevel != 3'd2; i++) tick();
        checkValue("t3_fill", 32'(fifoLevel), 32'd2);
        redirect     = 1'b1;
        redirectPc   = 16'h0100;
        bus.if_ready = 1'b1;
        #1;
        checkValue("t3_valid_in_redirect", 32'(bus.if_valid), 32'd0);
        tick();
        redirect = 1'b0;
        checkValue("t3_flush_level", 32'(fifoLevel),    32'd0);
        checkValue("t3_kill_req",    32'(bus.mem_req),  32'd1);
        checkValue("t3_kill_addr",   32'(bus.mem_addr), 32'h2);
        for (int i = 0; i < 20 && bus.mem_addr != 16'h0100; i++) tick();
        checkValue("t3_new_addr", 32'(bus.mem_addr), 32'h0100);
        checkValue("t3_new_req",  32'(bus.mem_req),  32'd1);
        for (int i = 0; i < 20 && gotPc.size() == 0; i++) tick();
        checkValue("t3_pops", 32'(gotPc.size() > 0), 32'd1);
        if (gotPc.size() > 0) begin
            checkValue("t3_first_pc", 32'(gotPc[0]), 32'h0100);
            checkValue("t3_first_ir", 32'(gotIr[0]), 32'hA4A5);
        end

        // 4: redirect with ack, then repeated redirects during KILL, last one with ack
        autoMem      = 1'b0;
        bus.if_ready = 1'b1;
        applyReset();
        tick();
        checkValue("t4_req",  32'(bus.mem_req),  32'd1);
        checkValue("t4_addr", 32'(bus.mem_addr), 32'h0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        redirect      = 1'b1;
        redirectPc    = 16'h0200;
        tick();
        bus.mem_ack = 1'b0;
        redirect    = 1'b0;
        checkValue("t4_addr_200", 32'(bus.mem_addr), 32'h0200);
        checkValue("t4_level0",   32'(fifoLevel),    32'd0);
        checkValue("t4_valid0",   32'(bus.if_valid), 32'd0);
        redirect   = 1'b1;
        redirectPc = 16'h0300;
        tick();
        checkValue("t4_kill_addr_a", 32'(bus.mem_addr), 32'h0200);
        redirectPc = 16'h0400;
        tick();
        checkValue("t4_kill_addr_b", 32'(bus.mem_addr), 32'h0200);
        redirectPc    = 16'h0500;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hBEEF;
        tick();
        redirect    = 1'b0;
        bus.mem_ack = 1'b0;
        checkValue("t4_addr_500", 32'(bus.mem_addr), 32'h0500);
        checkValue("t4_none",     32'(gotPc.size()), 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h1234;
        tick();
        bus.mem_ack = 1'b0;
        checkValue("t4_valid", 32'(bus.if_valid), 32'd1);
        checkValue("t4_pc",    32'(bus.if_pc),    32'h0500);
        checkValue("t4_ir",    32'(bus.if_ir),    32'h1234);
        checkValue("t4_level", 32'(fifoLevel),    32'd1);
        repeat (3) tick();
        checkValue("t4_delivered", 32'(gotPc.size()), 32'd1);
        if (gotPc.size() > 0) begin
            checkValue("t4_only_pc", 32'(gotPc[0]), 32'h0500);
        end

        // 6: asynchronous reset with a request outstanding and three words buffered
        autoMem      = 1'b1;
        ackDelay     = 1;
        bus.if_ready = 1'b0;
        applyReset();
        for (int i = 0; i < 40 && fifoLevel != 3'd3; i++) tick();
        checkValue("t6_pre_level", 32'(fifoLevel),   32'd3);
        checkValue("t6_pre_req",   32'(bus.mem_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkValue("t6_mem_req",  32'(bus.mem_req),  32'd0);
        checkValue("t6_mem_addr", 32'(bus.mem_addr), 32'h0);
        checkValue("t6_if_valid", 32'(bus.if_valid), 32'd0);
        checkValue("t6_if_ir",    32'(bus.if_ir),    32'h0);
        checkValue("t6_if_pc",    32'(bus.if_pc),    32'h0);
        checkValue("t6_level",    32'(fifoLevel),    32'd0);
        bus.if_ready = 1'b1;
        applyReset();
        repeat (12) tick();
        checkValue("t6_restart", 32'(gotPc.size() > 0), 32'd1);
        if (gotPc.size() > 0) begin
            checkValue("t6_first_pc", 32'(gotPc[0]), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
